// File: rtl/arithm_pkg.sv
// Shared arithmetic helpers for elaboration-time sizing.
package arithm_pkg;

  // Smallest r such that 2**r >= n (returns 0 for n <= 1).
  function automatic int unsigned log2ceil(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_downsizer.sv
// Splits each IN_WIDTH upstream word into RATIO OUT_WIDTH beats, ready/valid on both sides.
// A new word is taken in the same cycle the last beat of the previous one drains.
module stream_downsizer
  import arithm_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 s_valid_i,
  input  logic [IN_WIDTH-1:0]  s_data_i,
  output logic                 s_ready_o,
  output logic                 m_valid_o,
  output logic [OUT_WIDTH-1:0] m_data_o,
  output logic                 m_last_o,
  input  logic                 m_ready_i
);

  localparam int unsigned RATIO  = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned BEAT_W = log2ceil(RATIO);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

  if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_ratio
    $error("stream_downsizer: IN_WIDTH must be an integer multiple (>= 2) of OUT_WIDTH");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    BUSY  = 1'b1
  } state_t;

  state_t              state;
  logic [IN_WIDTH-1:0] word;
  logic [BEAT_W-1:0]   beat;
  logic [BEAT_W-1:0]   sel;
  logic                full;
  logic                at_last;

  assign full    = (state == BUSY);
  assign at_last = (beat == LAST_BEAT);

  // Ready also opens on the draining last beat so words stream without a bubble.
  assign s_ready_o = !rst_i && (!full || (m_ready_i && at_last));
  assign m_valid_o = full;
  assign m_last_o  = full && at_last;

  assign sel = MSB_FIRST ? (LAST_BEAT - beat) : beat;

  always_comb begin
    m_data_o = '0;
    if (full) begin
      m_data_o = word[32'(sel) * OUT_WIDTH +: OUT_WIDTH];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= EMPTY;
      word  <= '0;
      beat  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (s_valid_i) begin
            word  <= s_data_i;
            beat  <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (m_ready_i) begin
            if (!at_last) begin
              beat <= beat + BEAT_W'(1);
            end else begin
              beat <= '0;
              if (s_valid_i) begin
                word <= s_data_i;
              end else begin
                state <= EMPTY;
              end
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_downsizer.sv
// Bench for stream_downsizer: LSB-first and MSB-first instances share one stimulus stream.
module tb_stream_downsizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        m_ready = 1'b1;

  logic        s_ready, m_valid, m_last;
  logic [7:0]  m_data;
  logic        msb_s_ready, msb_m_valid, msb_m_last;
  logic [7:0]  msb_m_data;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  stream_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk_i(clk), .rst_i(rst), .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready),
    .m_valid_o(m_valid), .m_data_o(m_data), .m_last_o(m_last), .m_ready_i(m_ready)
  );

  stream_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk_i(clk), .rst_i(rst), .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(msb_s_ready),
    .m_valid_o(msb_m_valid), .m_data_o(msb_m_data), .m_last_o(msb_m_last), .m_ready_i(m_ready)
  );

  typedef struct {
    logic        rst;
    logic        sv;
    logic [31:0] sd;
    logic        mr;
    logic        er;
    logic        ev;
    logic [7:0]  ed;
    logic        el;
    logic [7:0]  emd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int unsigned r, input int unsigned sv, input logic [31:0] sd,
                     input int unsigned mr, input int unsigned er, input int unsigned ev,
                     input logic [7:0] ed, input int unsigned el, input logic [7:0] emd);
    vec_t v;
    v.rst = 1'(r);  v.sv = 1'(sv); v.sd = sd; v.mr = 1'(mr);
    v.er  = 1'(er); v.ev = 1'(ev); v.ed = ed; v.el = 1'(el); v.emd = emd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_row();
    add(0, 0, 32'h0, 1, 1, 0, 8'h00, 0, 8'h00);
  endtask

  logic [31:0] words [3];
  int widx, eidx, cyc;
  logic [7:0] prev_d;
  logic stalled;

  initial begin
    // Reset held three cycles, then release.
    for (int i = 0; i < 3; i++) add(1, 0, 32'h0, 1, 0, 0, 8'h00, 0, 8'h00);
    idle_row();
    // Single word, one beat per cycle.
    add(0, 1, 32'hA1B2C3D4, 1, 1, 0, 8'h00, 0, 8'h00);
    add(0, 0, 32'h0, 1, 0, 1, 8'hD4, 0, 8'hA1);
    add(0, 0, 32'h0, 1, 0, 1, 8'hC3, 0, 8'hB2);
    add(0, 0, 32'h0, 1, 0, 1, 8'hB2, 0, 8'hC3);
    add(0, 0, 32'h0, 1, 1, 1, 8'hA1, 1, 8'hD4);
    idle_row();
    // Back-to-back words, no bubble.
    add(0, 1, 32'h03020100, 1, 1, 0, 8'h00, 0, 8'h00);
    add(0, 1, 32'h07060504, 1, 0, 1, 8'h00, 0, 8'h03);
    add(0, 1, 32'h07060504, 1, 0, 1, 8'h01, 0, 8'h02);
    add(0, 1, 32'h07060504, 1, 0, 1, 8'h02, 0, 8'h01);
    add(0, 1, 32'h07060504, 1, 1, 1, 8'h03, 1, 8'h00);
    add(0, 0, 32'h0, 1, 0, 1, 8'h04, 0, 8'h07);
    add(0, 0, 32'h0, 1, 0, 1, 8'h05, 0, 8'h06);
    add(0, 0, 32'h0, 1, 0, 1, 8'h06, 0, 8'h05);
    add(0, 0, 32'h0, 1, 1, 1, 8'h07, 1, 8'h04);
    idle_row();
    // Backpressure at beat 2; a pending upstream word must be ignored.
    add(0, 1, 32'hA1B2C3D4, 1, 1, 0, 8'h00, 0, 8'h00);
    add(0, 0, 32'h0, 1, 0, 1, 8'hD4, 0, 8'hA1);
    add(0, 0, 32'h0, 1, 0, 1, 8'hC3, 0, 8'hB2);
    for (int i = 0; i < 5; i++) add(0, 1, 32'h55667788, 0, 0, 1, 8'hB2, 0, 8'hC3);
    add(0, 0, 32'h0, 1, 0, 1, 8'hB2, 0, 8'hC3);
    add(0, 0, 32'h0, 1, 1, 1, 8'hA1, 1, 8'hD4);
    idle_row();
    // Reset mid-word discards the remainder.
    add(0, 1, 32'hA1B2C3D4, 1, 1, 0, 8'h00, 0, 8'h00);
    add(0, 0, 32'h0, 1, 0, 1, 8'hD4, 0, 8'hA1);
    add(0, 0, 32'h0, 1, 0, 1, 8'hC3, 0, 8'hB2);
    add(1, 0, 32'h0, 1, 0, 0, 8'h00, 0, 8'h00);
    idle_row();
    add(0, 1, 32'h11223344, 1, 1, 0, 8'h00, 0, 8'h00);
    add(0, 0, 32'h0, 1, 0, 1, 8'h44, 0, 8'h11);
    add(0, 0, 32'h0, 1, 0, 1, 8'h33, 0, 8'h22);
    add(0, 0, 32'h0, 1, 0, 1, 8'h22, 0, 8'h33);
    add(0, 0, 32'h0, 1, 1, 1, 8'h11, 1, 8'h44);
    idle_row();

    foreach (vecs[i]) begin
      rst     = vecs[i].rst;
      s_valid = vecs[i].sv;
      s_data  = vecs[i].sd;
      m_ready = vecs[i].mr;
      #1;
      chk($sformatf("v%0d s_ready", i),   32'(s_ready),    32'(vecs[i].er));
      chk($sformatf("v%0d m_valid", i),   32'(m_valid),    32'(vecs[i].ev));
      chk($sformatf("v%0d m_data", i),    32'(m_data),     32'(vecs[i].ed));
      chk($sformatf("v%0d m_last", i),    32'(m_last),     32'(vecs[i].el));
      chk($sformatf("v%0d msb_data", i),  32'(msb_m_data), 32'(vecs[i].emd));
      chk($sformatf("v%0d msb_last", i),  32'(msb_m_last), 32'(vecs[i].el));
      @(posedge clk);
      #1;
    end

    // Random backpressure over a three-word stream against a byte-order model.
    words[0] = 32'hDEADBEEF;
    words[1] = 32'h0BADF00D;
    words[2] = 32'h12345678;
    widx = 0; eidx = 0; cyc = 0; stalled = 1'b0; prev_d = '0;
    while ((widx < 3 || eidx < 12) && cyc < 300) begin
      m_ready = 1'($urandom_range(0, 1));
      s_valid = (widx < 3);
      s_data  = (widx < 3) ? words[widx] : 32'h0;
      #1;
      if (stalled) begin
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_data", 32'(m_data), 32'(prev_d));
      end
      if (m_valid && m_ready) begin
        if (eidx < 12) begin
          chk($sformatf("rnd_beat%0d", eidx), 32'(m_data), 32'(8'(words[eidx / 4] >> (8 * (eidx % 4)))));
          chk($sformatf("rnd_last%0d", eidx), 32'(m_last), 32'((eidx % 4) == 3));
        end else begin
          tests++;
          failed++;
          $display("FAIL rnd_extra_beat: got %0h expected none", m_data);
        end
        eidx++;
      end
      stalled = m_valid && !m_ready;
      prev_d  = m_data;
      if (s_valid && s_ready) widx++;
      @(posedge clk);
      #1;
      cyc++;
    end
    tests++;
    if (cyc >= 300) begin
      failed++;
      $display("FAIL rnd_timeout: got %0d beats expected 12", eidx);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    #1;
    chk("rnd_drained", 32'(m_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/stream_downsizer.md
STREAM_DOWNSIZER -- requirements
Module: stream_downsizer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32, input word width in bits.
REQ-002 SHALL have parameter OUT_WIDTH, default 8, output beat width in bits.
REQ-003 SHALL have parameter MSB_FIRST, default 0; 0 = lowest slice emitted first, 1 = highest slice first.
REQ-004 SHALL have port clk_i, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-006 SHALL have port s_valid_i, input, 1, upstream word valid; fed by the dual-clock FIFO read side.
REQ-007 SHALL have port s_data_i, input, IN_WIDTH, upstream word.
REQ-008 SHALL have port s_ready_o, output, 1, word accepted on a clk_i edge where s_valid_i && s_ready_o.
REQ-009 SHALL have port m_valid_o, output, 1, output beat valid.
REQ-010 SHALL have port m_data_o, output, OUT_WIDTH, output beat.
REQ-011 SHALL have port m_last_o, output, 1, marks the final beat of the current word.
REQ-012 SHALL have port m_ready_i, input, 1, beat consumed on a clk_i edge where m_valid_o && m_ready_i.

Function
REQ-013 SHALL define RATIO = IN_WIDTH/OUT_WIDTH; IN_WIDTH not an integer multiple of OUT_WIDTH, or RATIO < 2, SHALL be an elaboration error.
REQ-014 SHALL hold state: word register (IN_WIDTH), beat counter (log2ceil(RATIO) bits), full flag.
REQ-015 SHALL use two states: EMPTY (full=0) and BUSY (full=1).
REQ-016 EMPTY: s_ready_o=1, m_valid_o=0; on accept, capture s_data_i, beat=0, go to BUSY.
REQ-017 BUSY: m_valid_o=1; m_data_o = slice beat (LSB-first: bits [beat*OUT_WIDTH +: OUT_WIDTH]; MSB-first: slice RATIO-1-beat).
REQ-018 BUSY, beat consumed and beat < RATIO-1: beat increments by 1; word register unchanged.
REQ-019 BUSY, beat consumed and beat == RATIO-1: if s_valid_i, capture new word, beat=0, stay BUSY; else go to EMPTY, beat=0.
REQ-020 s_ready_o SHALL equal !full || (m_ready_i && beat == RATIO-1); this combinational m_ready_i-to-s_ready_o path is intended.
REQ-021 m_last_o SHALL equal full && beat == RATIO-1.
REQ-022 Latency: a word accepted on edge N SHALL present its first beat from cycle N+1.
REQ-023 Throughput: with m_ready_i held high and s_valid_i held high, one beat every cycle and no bubble between words.
REQ-024 Stall: while m_valid_o && !m_ready_i, m_data_o and m_last_o SHALL hold stable, and s_ready_o SHALL be 0 in BUSY.
REQ-025 Beat counter SHALL never exceed RATIO-1; wrap from RATIO-1 to 0 only through REQ-019.
REQ-026 s_valid_i with s_ready_o=0 SHALL have no effect; upstream holds the word (FIFO semantics).

Reset
REQ-027 While rst_i is high: full=0, beat=0, word register=0; m_valid_o=0, m_last_o=0, m_data_o=0, s_ready_o=0.
REQ-028 First edge after rst_i falls: EMPTY with s_ready_o=1.
REQ-029 Reset asserted mid-word SHALL discard the held word and remaining beats; no beat of it SHALL appear after reset.

Structure
REQ-030 log2ceil SHALL come from arithm_pkg; no new package types required.
REQ-031 SHALL be a single module with an inline beat counter; counter_param is not reused (it uses active-low reset and has no load/clear).

Verification
REQ-032 Reset: rst_i=1 for 3 cycles -> m_valid_o=0, s_ready_o=0; after release s_ready_o=1, m_valid_o=0.
REQ-033 Single word, LSB-first, defaults: s_data_i=32'hA1B2C3D4, m_ready_i=1 -> beats D4,C3,B2,A1 on cycles N+1..N+4, m_last_o only with A1, then m_valid_o=0.
REQ-034 Back-to-back: words 32'h03020100 and 32'h07060504 continuous, m_ready_i=1 -> 8 consecutive beats 00..07, no gap, s_ready_o=1 in last-beat cycles only.
REQ-035 Backpressure: m_ready_i=0 for 5 cycles at beat 2 of 32'hA1B2C3D4 -> m_data_o holds B2, s_ready_o=0; resumes B2,A1 after release.
REQ-036 MSB_FIRST=1: 32'hA1B2C3D4 -> beats A1,B2,C3,D4, m_last_o with D4.
REQ-037 Mid-word reset: rst_i pulsed after beat C3 of 32'hA1B2C3D4 -> no B2/A1 emitted; next word 32'h11223344 emits 44,33,22,11.
